// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode/state types and flag bit positions for alu_seq_unit
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } state_e;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == LAST_ITER) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // done marks the cycle whose edge applies the final partial product
    assign done_o    = busy_q && (cnt_q == LAST_ITER);
    assign product_o = acc_q;

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - handshaked ALU with iterative MUL; ALU_SEQ_FLAGS_EN adds the out_flags port
module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ALU_SEQ_FLAGS_EN
    output logic [3:0]       out_flags,
`endif
    output logic [WIDTH-1:0] out_result
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_prod;
    logic [SHW-1:0]   shamt;
    logic             mul_start, mul_done;
    logic             in_fire, out_fire;
    opcode_e          op;

    assign op       = opcode_e'(in_opcode);
    assign shamt    = in_b[SHW-1:0];
    assign in_ready = reset_n && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_SLL:  alu_res = in_a << shamt;
            OP_SRL:  alu_res = in_a >> shamt;
            default: alu_res = '0;
        endcase
    end

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clock     (clock),
        .reset_n   (reset_n),
        .start_i   (mul_start),
        .a_i       (in_a),
        .b_i       (in_b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        mul_start   = 1'b0;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = MUL_BUSY;
                    end else begin
                        result_d    = alu_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                result_d    = mul_prod;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = result_q;

`ifdef ALU_SEQ_FLAGS_EN
    logic [3:0]     alu_flags, flags_q;
    logic [SHW-1:0] sll_idx, srl_idx;
    logic           shift_out_ok;

    // Last bit shifted out: a[WIDTH-s] for SLL, a[s-1] for SRL; none when s==0
    assign sll_idx      = SHW'(WIDTH - int'(shamt));
    assign srl_idx      = shamt - SHW'(1);
    assign shift_out_ok = (shamt != '0) && (int'(shamt) <= WIDTH);

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
        case (op)
            OP_ADD: begin
                alu_flags[FLAG_C] = (alu_res < in_a);
                alu_flags[FLAG_V] = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_flags[FLAG_C] = (in_a < in_b);
                alu_flags[FLAG_V] = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SLL:  alu_flags[FLAG_C] = shift_out_ok && in_a[sll_idx];
            OP_SRL:  alu_flags[FLAG_C] = shift_out_ok && in_a[srl_idx];
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if (state_q == MUL_DONE) begin
            flags_q <= {mul_prod[WIDTH-1], (mul_prod == '0), 2'b00};
        end else if (state_q == IDLE && in_fire && op != OP_MUL) begin
            flags_q <= alu_flags;
        end
    end

    assign out_flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - directed self-checking bench for alu_seq_unit (WIDTH=32)
module tb_alu_seq_unit;
    import alu_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_opcode;
    logic [31:0] in_a, in_b, out_result;
`ifdef ALU_SEQ_FLAGS_EN
    logic [3:0]  out_flags;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    alu_seq_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef ALU_SEQ_FLAGS_EN
        .out_flags  (out_flags),
`endif
        .out_result (out_result)
    );

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        in_opcode = op; in_a = a; in_b = b; in_valid = 1'b1; n = 0;
        while (!in_ready && n < 100) begin @(posedge clock); #1; n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL send_timeout in_ready=%b required=1", in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clock); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", out_result); end
        reset_n = 1'b1;
        @(posedge clock); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        send(OP_ADD, 32'd10, 32'd15);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        total++; if (out_result !== 32'd25) begin bad++; $display("FAIL add_result got=%h exp=%h", out_result, 32'd25); end
`ifdef ALU_SEQ_FLAGS_EN
        total++; if (out_flags !== 4'b0000) begin bad++; $display("FAIL add_flags got=%b exp=0000", out_flags); end
`endif
        @(posedge clock); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_sub();
        send(OP_SUB, 32'd20, 32'd5);
        total++; if (out_result !== 32'd15) begin bad++; $display("FAIL sub_pos got=%h exp=%h", out_result, 32'd15); end
        send(OP_SUB, 32'd5, 32'd20);
        total++; if (out_result !== 32'hFFFF_FFF1) begin bad++; $display("FAIL sub_neg got=%h exp=fffffff1", out_result); end
`ifdef ALU_SEQ_FLAGS_EN
        total++; if (out_flags !== 4'b1010) begin bad++; $display("FAIL sub_neg_flags got=%b exp=1010", out_flags); end
`endif
    endtask

    task automatic test_logic_shift();
        send(OP_AND, 32'hF0F0, 32'hFF00);
        total++; if (out_result !== 32'hF000) begin bad++; $display("FAIL and got=%h exp=f000", out_result); end
        send(OP_OR, 32'h0F, 32'hF0);
        total++; if (out_result !== 32'hFF) begin bad++; $display("FAIL or got=%h exp=ff", out_result); end
        send(OP_SLL, 32'h8000_0001, 32'd4);
        total++; if (out_result !== 32'h10) begin bad++; $display("FAIL sll got=%h exp=10", out_result); end
`ifdef ALU_SEQ_FLAGS_EN
        total++; if (out_flags !== 4'b0000) begin bad++; $display("FAIL sll_flags got=%b exp=0000", out_flags); end
`endif
        send(OP_SLL, 32'h1, 32'd33);
        total++; if (out_result !== 32'h2) begin bad++; $display("FAIL sll_mask got=%h exp=2", out_result); end
        send(OP_SRL, 32'h84, 32'd3);
        total++; if (out_result !== 32'h10) begin bad++; $display("FAIL srl got=%h exp=10", out_result); end
`ifdef ALU_SEQ_FLAGS_EN
        total++; if (out_flags !== 4'b0010) begin bad++; $display("FAIL srl_flags got=%b exp=0010", out_flags); end
`endif
    endtask

    task automatic test_add_boundary();
        send(OP_ADD, 32'hFFFF_FFFF, 32'd1);
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL add_wrap got=%h exp=0", out_result); end
`ifdef ALU_SEQ_FLAGS_EN
        total++; if (out_flags !== 4'b0110) begin bad++; $display("FAIL add_wrap_flags got=%b exp=0110", out_flags); end
`endif
        send(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        total++; if (out_result !== 32'h8000_0000) begin bad++; $display("FAIL add_ovf got=%h exp=80000000", out_result); end
`ifdef ALU_SEQ_FLAGS_EN
        total++; if (out_flags !== 4'b1001) begin bad++; $display("FAIL add_ovf_flags got=%b exp=1001", out_flags); end
`endif
    endtask

    task automatic test_mul();
        int k, busy_ready;
        send(OP_MUL, 32'd7, 32'd6);
        // offer a follow-on ADD with different operands while the multiply runs
        in_opcode = OP_ADD; in_a = 32'd1; in_b = 32'd2; in_valid = 1'b1;
        k = 0; busy_ready = 0;
        while (!out_valid && k < 60) begin
            if (in_ready) busy_ready++;
            @(posedge clock); #1; k++;
        end
        total++; if (k !== 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", k); end
        total++; if (busy_ready !== 0) begin bad++; $display("FAIL mul_in_ready_busy got=%0d exp=0", busy_ready); end
        total++; if (out_result !== 32'd42) begin bad++; $display("FAIL mul_result got=%h exp=%h", out_result, 32'd42); end
`ifdef ALU_SEQ_FLAGS_EN
        total++; if (out_flags !== 4'b0000) begin bad++; $display("FAIL mul_flags got=%b exp=0000", out_flags); end
`endif
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mul_idle_ready got=%b exp=1", in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_result !== 32'd3) begin
            bad++; $display("FAIL mul_followon got=%b/%h exp=1/3", out_valid, out_result);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int unstable;
        out_ready = 1'b0;
        send(OP_XOR, 32'hF0, 32'hFF);
        in_opcode = OP_OR; in_a = 32'h3; in_b = 32'h5; in_valid = 1'b1;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_result !== 32'h0F || in_ready !== 1'b0) unstable++;
            @(posedge clock); #1;
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL hold_stable got=%0d cycles unstable exp=0", unstable); end
        total++; if (out_result !== 32'h0F) begin bad++; $display("FAIL hold_result got=%h exp=0f", out_result); end
        out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_result !== 32'h7) begin
            bad++; $display("FAIL b2b_result got=%b/%h exp=1/7", out_valid, out_result);
        end
        @(posedge clock); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_mul_reset();
        int seen;
        send(OP_MUL, 32'd3, 32'd5);
        repeat (10) @(posedge clock);
        #1; reset_n = 1'b0; #1;
        total++; if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mul_rst got=%b/%h/%b exp=0/0/0", out_valid, out_result, in_ready);
        end
        repeat (2) @(posedge clock);
        #1; reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL mul_rst_ghost got=%0d results exp=0", seen); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mul_rst_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic_shift();
        test_add_boundary();
        test_mul();
        test_back_to_back();
        test_mul_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
